// File: rtl/mul_pkg.sv
// Shared definitions for the HI/LO multiply controller: op encodings, FSM states, product width.
package mul_pkg;

  localparam int PROD_W = 64;

  // op = {acc_sub, acc_en, sign}
  localparam logic [2:0] OP_MULTU = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MADDU = 3'b010;
  localparam logic [2:0] OP_MADD  = 3'b011;
  localparam logic [2:0] OP_MSUBU = 3'b110;
  localparam logic [2:0] OP_MSUB  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_ACC  = 2'd2
  } state_t;

  function automatic logic op_signed(input logic [2:0] op);
    return op[0];
  endfunction

  function automatic logic op_acc_en(input logic [2:0] op);
    return op[1];
  endfunction

  function automatic logic op_acc_sub(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/my_mul.sv
// Combinational 32x32 multiplier producing a 64-bit product, signed or unsigned per 'sign'.
module my_mul (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sign,
  output logic [63:0] product
);

  logic [63:0] a_ext;
  logic [63:0] b_ext;

  // Low 64 bits of the extended product are correct for both signed and unsigned operands.
  assign a_ext   = {{32{sign & a[31]}}, a};
  assign b_ext   = {{32{sign & b[31]}}, b};
  assign product = a_ext * b_ext;

endmodule

// File: rtl/mul_hilo_ctrl.sv
// HI/LO multiply controller: IDLE -> CALC -> ACC with direct HI/LO writes and flush.
// Accumulate ops (MADD/MADDU/MSUB/MSUBU) are built only when MUL_HILO_ACC_EN is defined.
module mul_hilo_ctrl
  import mul_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         flush,
  input  logic [1:0]   hilo_we,
  input  logic [W-1:0] hilo_wdata,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  state_t              state;
  logic [W-1:0]        a_q;
  logic [W-1:0]        b_q;
  logic [2:0]          op_q;
  logic [PROD_W-1:0]   prod_q;
  logic [PROD_W-1:0]   product;
  logic [PROD_W-1:0]   hilo_next;

  my_mul u_mul (
    .a       (a_q),
    .b       (b_q),
    .sign    (op_signed(op_q)),
    .product (product)
  );

  assign ready = (state == ST_IDLE) && !(|hilo_we);

`ifdef MUL_HILO_ACC_EN
  always_comb begin
    hilo_next = prod_q;
    if (op_acc_en(op_q)) begin
      hilo_next = op_acc_sub(op_q) ? ({hi, lo} - prod_q) : ({hi, lo} + prod_q);
    end
  end
`else
  logic unused_acc_bits;

  // Without accumulate support every op collapses to MULT/MULTU.
  assign unused_acc_bits = ^op_q[2:1];
  assign hilo_next       = prod_q;
`endif

  // Direct writes beat start in IDLE; flush and busy both mask direct writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      prod_q <= '0;
      hi     <= '0;
      lo     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!flush) begin
            if (|hilo_we) begin
              if (hilo_we[1]) hi <= hilo_wdata;
              if (hilo_we[0]) lo <= hilo_wdata;
            end else if (start) begin
              a_q   <= a;
              b_q   <= b;
              op_q  <= op;
              busy  <= 1'b1;
              state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (flush) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            prod_q <= product;
            state  <= ST_ACC;
          end
        end
        ST_ACC: begin
          if (!flush) begin
            {hi, lo} <= hilo_next;
            done     <= 1'b1;
          end
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
